// File: rtl/vend_sequencer_if.sv
// Handshake and status bundle between the vending sequencer and its environment
// (payment block, selection panel, dispense mechanism).
interface vend_sequencer_if;
  logic       select;
  logic [3:0] selIndex;
  logic       cancelBtn;
  logic       restock;
  logic       changeState;
  logic       reduceInventory;
  logic       cancelledDone;
  logic [1:0] state;
  logic [3:0] curIndex;
  logic       fullInventory;
  logic       changeStateDone;
  logic       reduceInventoryDone;
  logic       cancelled;
  logic       dispense;
  logic [3:0] dispenseIndex;
  logic       soldOut;

  modport slave (
    input  select, selIndex, cancelBtn, restock, changeState, reduceInventory, cancelledDone,
    output state, curIndex, fullInventory, changeStateDone, reduceInventoryDone,
           cancelled, dispense, dispenseIndex, soldOut
  );

  modport master (
    output select, selIndex, cancelBtn, restock, changeState, reduceInventory, cancelledDone,
    input  state, curIndex, fullInventory, changeStateDone, reduceInventoryDone,
           cancelled, dispense, dispenseIndex, soldOut
  );
endinterface

// File: rtl/vend_sequencer.sv
// Vending sequencer: SELECT/PAY/CANCEL/SERVICE state machine, four-phase
// handshakes with the payment block, and one inventory counter per item slot.

module vend_slot #(
  parameter int INV_W      = 4,
  parameter int INIT_COUNT = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  output logic [INV_W-1:0] count
);
  logic [INV_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load)                     count_d = INV_W'(INIT_COUNT);
    else if (dec && count_q != '0) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= INV_W'(INIT_COUNT);
    else      count_q <= count_d;
  end

  assign count = count_q;
endmodule

module vend_sequencer #(
  parameter int NUM_ITEMS  = 8,
  parameter int INV_W      = 4,
  parameter int INIT_COUNT = 5
) (
  input  logic        clk,
  input  logic        rst,
  vend_sequencer_if.slave bus
);
  typedef enum logic [1:0] {
    S_SELECT  = 2'b00,
    S_PAY     = 2'b01,
    S_CANCEL  = 2'b10,
    S_SERVICE = 2'b11
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cur_idx_q, cur_idx_d;
  logic [3:0] disp_idx_q, disp_idx_d;
  logic       cs_done_q, cs_done_d;
  logic       ri_done_q, ri_done_d;
  logic       cancelled_q, cancelled_d;
  logic       dispense_q, dispense_d;
  logic       sold_flag_q, sold_flag_d;

  logic [NUM_ITEMS-1:0][INV_W-1:0] count;
  logic [15:0] nonzero;
  logic        load_all, dec_fire, sold_out, sel_ok;

  for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_slot
    vend_slot #(.INV_W(INV_W), .INIT_COUNT(INIT_COUNT)) u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (load_all),
      .dec   (dec_fire && (cur_idx_q == 4'(i))),
      .count (count[i])
    );
  end

  // Stock flags padded to the full 4-bit index space so out-of-range
  // selections read as empty instead of indexing past the array.
  for (genvar i = 0; i < 16; i++) begin : g_nz
    if (i < NUM_ITEMS) begin : g_on
      assign nonzero[i] = |count[i];
    end else begin : g_off
      assign nonzero[i] = 1'b0;
    end
  end

  assign sold_out = ~|nonzero;
  assign sel_ok   = bus.select && ({1'b0, bus.selIndex} < 5'(NUM_ITEMS)) && nonzero[bus.selIndex];

  always_comb begin
    state_d     = state_q;
    cur_idx_d   = cur_idx_q;
    disp_idx_d  = disp_idx_q;
    dispense_d  = 1'b0;
    cancelled_d = cancelled_q;
    sold_flag_d = sold_flag_q;
    load_all    = 1'b0;
    dec_fire    = 1'b0;
    // Dones release on request fall regardless of state
    cs_done_d   = bus.changeState     ? cs_done_q : 1'b0;
    ri_done_d   = bus.reduceInventory ? ri_done_q : 1'b0;

    case (state_q)
      S_SELECT: begin
        if (bus.restock || sold_out) begin
          state_d = S_SERVICE;
        end else if (sel_ok) begin
          cur_idx_d   = bus.selIndex;
          sold_flag_d = 1'b0;
          state_d     = S_PAY;
        end
      end
      S_PAY: begin
        if (bus.reduceInventory && !ri_done_q) begin
          dec_fire    = 1'b1;
          dispense_d  = 1'b1;
          disp_idx_d  = cur_idx_q;
          ri_done_d   = 1'b1;
          sold_flag_d = 1'b1;
        end
        if (bus.changeState && !cs_done_q) cs_done_d = 1'b1;
        if (sold_flag_q && !bus.changeState && !bus.reduceInventory && !cs_done_q && !ri_done_q) begin
          state_d = sold_out ? S_SERVICE : S_SELECT;
        end else if (bus.cancelBtn && !sold_flag_q && !bus.reduceInventory) begin
          state_d     = S_CANCEL;
          cancelled_d = 1'b1;
        end
      end
      S_CANCEL: begin
        if (cancelled_q) begin
          if (bus.cancelledDone) cancelled_d = 1'b0;
        end else if (!bus.cancelledDone) begin
          state_d = S_SELECT;
        end
      end
      S_SERVICE: begin
        load_all = bus.restock;
        if (!bus.restock && !sold_out) state_d = S_SELECT;
      end
      default: state_d = S_SELECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_SELECT;
      cur_idx_q   <= '0;
      disp_idx_q  <= '0;
      cs_done_q   <= 1'b0;
      ri_done_q   <= 1'b0;
      cancelled_q <= 1'b0;
      dispense_q  <= 1'b0;
      sold_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_idx_q   <= cur_idx_d;
      disp_idx_q  <= disp_idx_d;
      cs_done_q   <= cs_done_d;
      ri_done_q   <= ri_done_d;
      cancelled_q <= cancelled_d;
      dispense_q  <= dispense_d;
      sold_flag_q <= sold_flag_d;
    end
  end

  assign bus.state               = state_q;
  assign bus.curIndex            = cur_idx_q;
  assign bus.fullInventory       = nonzero[cur_idx_q];
  assign bus.changeStateDone     = cs_done_q;
  assign bus.reduceInventoryDone = ri_done_q;
  assign bus.cancelled           = cancelled_q;
  assign bus.dispense            = dispense_q;
  assign bus.dispenseIndex       = disp_idx_q;
  assign bus.soldOut             = sold_out;
endmodule

// File: tb/tb_vend_sequencer.sv
// Randomized bench for vend_sequencer against a transaction-level inventory model.
module tb_vend_sequencer;
  localparam int NI = 8;
  localparam int IW = 4;
  localparam int IC = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vend_sequencer_if bus();
  vend_sequencer #(.NUM_ITEMS(NI), .INV_W(IW), .INIT_COUNT(IC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int inv[NI];
  int n_disp = 0;
  bit saw_cancel = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    if (bus.dispense === 1'b1) n_disp++;
    if (bus.state === 2'b10) saw_cancel = 1'b1;
  endtask

  task automatic idle();
    bus.select = 0; bus.selIndex = 0; bus.cancelBtn = 0; bus.restock = 0;
    bus.changeState = 0; bus.reduceInventory = 0; bus.cancelledDone = 0;
  endtask

  function automatic bit m_sold();
    foreach (inv[i]) if (inv[i] != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_reload();
    foreach (inv[i]) inv[i] = IC;
  endtask

  task automatic chk_counts(input string tag);
    for (int i = 0; i < NI; i++) chk(tag, dut.count[i], inv[i]);
  endtask

  // Full purchase: select, reduceInventory, changeState, release
  task automatic buy(input int idx, input bit rnd);
    bit ok;
    ok = (idx < NI) && (inv[idx] > 0);
    bus.select = 1; bus.selIndex = 4'(idx); step(); bus.select = 0;
    chk("sel_state", bus.state, ok ? 1 : 0);
    if (!ok) return;
    chk("sel_idx", bus.curIndex, idx);
    if (rnd) repeat ($urandom_range(0, 2)) step();
    bus.reduceInventory = 1; step();
    inv[idx]--;
    chk("disp_on", bus.dispense, 1);
    chk("disp_idx", bus.dispenseIndex, idx);
    chk("ri_done", bus.reduceInventoryDone, 1);
    chk("cnt_dec", dut.count[idx], inv[idx]);
    chk("full_inv", bus.fullInventory, inv[idx] != 0);
    chk("sold_out", bus.soldOut, m_sold());
    step();
    chk("disp_pulse", bus.dispense, 0);
    bus.changeState = 1; step();
    chk("cs_done", bus.changeStateDone, 1);
    if (rnd) repeat ($urandom_range(0, 2)) step();
    bus.reduceInventory = 0; bus.changeState = 0; step();
    chk("ri_rel", bus.reduceInventoryDone, 0);
    chk("cs_rel", bus.changeStateDone, 0);
    chk("pay_hold", bus.state, 1);
    step();
    chk("exit_state", bus.state, m_sold() ? 3 : 0);
  endtask

  task automatic cancel_tx(input int idx, input int hold);
    bus.select = 1; bus.selIndex = 4'(idx); step(); bus.select = 0;
    chk("c_sel", bus.state, 1);
    bus.cancelBtn = 1; step(); bus.cancelBtn = 0;
    chk("c_state", bus.state, 2);
    chk("c_req", bus.cancelled, 1);
    step();
    chk("c_hold", bus.cancelled, 1);
    bus.cancelledDone = 1; step();
    chk("c_drop", bus.cancelled, 0);
    chk("c_wait", bus.state, 2);
    repeat (hold - 1) step();
    bus.cancelledDone = 0; step();
    chk("c_exit", bus.state, 0);
    chk("c_idx", bus.curIndex, idx);
  endtask

  task automatic restock_tx();
    bus.restock = 1; step();
    chk("rs_enter", bus.state, 3);
    step(); bus.restock = 0;
    m_reload();
    chk_counts("rs_cnt");
    step();
    chk("rs_exit", bus.state, 0);
  endtask

  function automatic int pick_stocked();
    for (int t = 0; t < 64; t++) begin
      int k = $urandom_range(0, NI - 1);
      if (inv[k] > 0) return k;
    end
    foreach (inv[i]) if (inv[i] > 0) return i;
    return -1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, k;
    idle();
    m_reload();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", bus.state, 0);
    chk("rst_idx", bus.curIndex, 0);
    chk("rst_didx", bus.dispenseIndex, 0);
    chk("rst_disp", bus.dispense, 0);
    chk("rst_done", {bus.changeStateDone, bus.reduceInventoryDone, bus.cancelled}, 0);
    chk("rst_full", bus.fullInventory, 1);
    chk("rst_sold", bus.soldOut, 0);
    chk_counts("rst_cnt");
    rst = 1;
    step();

    buy(3, 0);
    for (int i = 0; i < 5; i++) buy(2, 0);
    buy(2, 0);
    buy(12, 0);
    buy(9, 0);

    d0 = n_disp; saw_cancel = 0;
    cancel_tx(1, 2);
    chk("c_nodisp", n_disp, d0);
    chk("c_cnt", dut.count[1], inv[1]);

    // cancel racing a purchase in the same cycle
    saw_cancel = 0;
    bus.select = 1; bus.selIndex = 4; step(); bus.select = 0;
    bus.cancelBtn = 1; bus.reduceInventory = 1; step(); bus.cancelBtn = 0;
    inv[4]--;
    chk("race_disp", bus.dispense, 1);
    chk("race_state", bus.state, 1);
    chk("race_cncl", bus.cancelled, 0);
    bus.changeState = 1; step(); step();
    bus.changeState = 0; bus.reduceInventory = 0; step(); step();
    chk("race_exit", bus.state, 0);
    chk("race_never", saw_cancel, 0);
    chk("race_cnt", dut.count[4], inv[4]);

    // cancelBtn in SELECT is ignored
    bus.cancelBtn = 1; step(); bus.cancelBtn = 0;
    chk("sel_cncl", bus.state, 0);

    for (int n = 0; n < 40; n++) begin
      int r = $urandom_range(0, 9);
      if (r < 6) buy($urandom_range(0, 11), 1);
      else if (r < 8) begin
        k = pick_stocked();
        if (k >= 0) cancel_tx(k, $urandom_range(1, 3));
      end else restock_tx();
      if (bus.state == 2'b11) begin
        bus.restock = 1; step(); bus.restock = 0;
        m_reload(); step();
        chk("rnd_recover", bus.state, 0);
      end
    end
    chk_counts("rnd_cnt");

    // sell everything out
    for (int i = 0; i < NI; i++) while (inv[i] > 0) buy(i, 0);
    chk("so_flag", bus.soldOut, 1);
    chk("so_state", bus.state, 3);
    bus.select = 1; bus.selIndex = 0; step(); bus.select = 0;
    chk("so_sel", bus.state, 3);
    step();
    chk("so_stay", bus.state, 3);
    bus.restock = 1; step(); bus.restock = 0;
    m_reload();
    chk_counts("so_reload");
    step();
    chk("so_exit", bus.state, 0);

    // reset while a dispense handshake is open
    buy(5, 0);
    bus.select = 1; bus.selIndex = 6; step(); bus.select = 0;
    bus.reduceInventory = 1; bus.changeState = 1; step();
    chk("mid_ri", bus.reduceInventoryDone, 1);
    rst = 0; #2;
    m_reload();
    chk("mid_state", bus.state, 0);
    chk("mid_done", {bus.changeStateDone, bus.reduceInventoryDone}, 0);
    chk("mid_disp", bus.dispense, 0);
    chk("mid_idx", bus.curIndex, 0);
    chk("mid_didx", bus.dispenseIndex, 0);
    chk("mid_full", bus.fullInventory, 1);
    chk_counts("mid_cnt");
    step();
    rst = 1;
    d0 = n_disp;
    step(); step();
    chk("mid_nodisp", n_disp, d0);
    chk("mid_sel", bus.state, 0);
    idle(); step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
